wb_reg_timeout: RTL and testbench

WB_REG_TIMEOUT -- requirements
Module: wb_reg_timeout

---
 rtl/wb_reg_timeout.sv | 176 +++++++++++++++++
 tb/tb_wb_reg_timeout.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_timeout.sv
// Registered Wishbone pipeline stage with a downstream response timeout.
// Every output is a flop; a silent slave is answered with an error after TIMEOUT_CYCLES.
module wb_reg_timeout #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o,

    output logic                    timeout_o
);

    localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    we_q, we_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic                    stb_q, stb_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    rty_q, rty_d;
    logic                    tmo_q, tmo_d;

    logic start, abort, resp_in, tmo_fire;

    // Event decode shared by next-state and output logic; abort outranks a
    // response, and a response outranks a timeout in the same cycle.
    always_comb begin
        start    = wbm_cyc_i && wbm_stb_i;
        abort    = !wbm_cyc_i;
        resp_in  = wbs_ack_i || wbs_err_i || wbs_rty_i;
        tmo_fire = TMO_EN && (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            stb_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            stb_q   <= stb_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rty_q   <= rty_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (abort)                   state_d = IDLE;
                else if (resp_in || tmo_fire) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        adr_d  = adr_q;
        wdat_d = wdat_q;
        rdat_d = rdat_q;
        we_d   = we_q;
        sel_d  = sel_q;
        stb_d  = stb_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rty_d  = 1'b0;
        tmo_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    adr_d  = wbm_adr_i;
                    wdat_d = wbm_dat_i;
                    we_d   = wbm_we_i;
                    sel_d  = wbm_sel_i;
                    stb_d  = 1'b1;
                    cnt_d  = CNT_W'(TIMEOUT_CYCLES);
                end
            end
            ACTIVE: begin
                if (abort) begin
                    stb_d = 1'b0;
                end else if (resp_in) begin
                    stb_d  = 1'b0;
                    rdat_d = wbs_dat_i;
                    ack_d  = wbs_ack_i;
                    err_d  = !wbs_ack_i && wbs_err_i;
                    rty_d  = !wbs_ack_i && !wbs_err_i && wbs_rty_i;
                end else if (tmo_fire) begin
                    stb_d = 1'b0;
                    err_d = 1'b1;
                    tmo_d = 1'b1;
                end else if (TMO_EN) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Strobe and cycle always move together, so one flop drives both.
    always_comb begin
        wbs_adr_o = adr_q;
        wbs_dat_o = wdat_q;
        wbs_we_o  = we_q;
        wbs_sel_o = sel_q;
        wbs_stb_o = stb_q;
        wbs_cyc_o = stb_q;
        wbm_dat_o = rdat_q;
        wbm_ack_o = ack_q;
        wbm_err_o = err_q;
        wbm_rty_o = rty_q;
        timeout_o = tmo_q;
    end

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Directed bench for wb_reg_timeout: per-cycle expectations are queued when a
// cycle is driven and popped after the following clock edge.
module tb_wb_reg_timeout;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm_adr_i, wbm_dat_i, wbs_dat_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_we_i, wbm_stb_i, wbm_cyc_i;
    logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

    logic [31:0] wbm_dat_o, wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o, wbs_we_o, wbs_stb_o, wbs_cyc_o, timeout_o;

    logic [31:0] z_dat_o, z_adr_o, z_wdat_o;
    logic [3:0]  z_sel_o;
    logic        z_ack_o, z_err_o, z_rty_o, z_we_o, z_stb_o, z_cyc_o, z_tmo_o;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [31:0] dat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    wb_reg_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(wbs_cyc_o), .timeout_o(timeout_o)
    );

    // Timeout disabled, downstream permanently silent.
    wb_reg_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(z_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(z_ack_o), .wbm_err_o(z_err_o), .wbm_rty_o(z_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(z_adr_o), .wbs_dat_i(32'h0), .wbs_dat_o(z_wdat_o),
        .wbs_we_o(z_we_o), .wbs_sel_o(z_sel_o), .wbs_stb_o(z_stb_o),
        .wbs_ack_i(1'b0), .wbs_err_i(1'b0), .wbs_rty_i(1'b0),
        .wbs_cyc_o(z_cyc_o), .timeout_o(z_tmo_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive current inputs for one cycle; expect given outputs in the next cycle.
    task automatic step(input string tag, input logic stb, input logic ack, input logic err,
                        input logic rty, input logic tmo, input logic [31:0] dat);
        exp_t e;
        e.tag = tag;
        e.ctl = {stb, stb, ack, err, rty, tmo};
        e.dat = dat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({e.tag, " ctl{stb,cyc,ack,err,rty,tmo}"},
            64'({wbs_stb_o, wbs_cyc_o, wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}), 64'(e.ctl));
        chk({e.tag, " wbm_dat_o"}, 64'(wbm_dat_o), 64'(e.dat));
    endtask

    task automatic idle_inputs();
        wbm_stb_i = 1'b0;
        wbs_ack_i = 1'b0;
        wbs_err_i = 1'b0;
        wbs_rty_i = 1'b0;
    endtask

    task automatic request(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                           input logic [3:0] sel);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        wbm_cyc_i = 1'b0;
        wbm_adr_i = '0; wbm_dat_i = '0; wbm_we_i = 1'b0; wbm_sel_i = '0;
        wbs_dat_i = '0;
        idle_inputs();

        // Reset state
        step("reset", 0, 0, 0, 0, 0, 32'h0);
        chk("reset wbs_adr/dat/sel/we", {wbs_adr_o, wbs_dat_o[30:0], wbs_sel_o, wbs_we_o}, 64'h0);
        rst = 1'b0;

        // Read with ack in the second strobe cycle
        request(32'h1000, 32'h0, 1'b0, 4'hF);
        step("rd c1", 1, 0, 0, 0, 0, 32'h0);
        chk("rd adr", 64'(wbs_adr_o), 64'h1000);
        idle_inputs();
        step("rd c2", 1, 0, 0, 0, 0, 32'h0);
        wbs_ack_i = 1'b1; wbs_dat_i = 32'hDEADBEEF;
        step("rd c3 ack", 0, 1, 0, 0, 0, 32'hDEADBEEF);
        idle_inputs();
        wbm_cyc_i = 1'b0;
        step("rd c4 idle", 0, 0, 0, 0, 0, 32'hDEADBEEF);

        // Write acked on first strobe, then back-to-back request
        request(32'h20, 32'h12345678, 1'b1, 4'hF);
        step("wr c1", 1, 0, 0, 0, 0, 32'hDEADBEEF);
        chk("wr wbs_adr", 64'(wbs_adr_o), 64'h20);
        chk("wr wbs_dat", 64'(wbs_dat_o), 64'h12345678);
        chk("wr wbs_we/sel", 64'({wbs_we_o, wbs_sel_o}), 64'h1F);
        idle_inputs();
        wbs_ack_i = 1'b1; wbs_dat_i = 32'hA5A5A5A5;
        step("wr c2 ack", 0, 1, 0, 0, 0, 32'hA5A5A5A5);
        idle_inputs();
        step("wr c3 idle", 0, 0, 0, 0, 0, 32'hA5A5A5A5);
        request(32'h24, 32'h55, 1'b0, 4'h3);
        step("b2b c4", 1, 0, 0, 0, 0, 32'hA5A5A5A5);
        chk("b2b adr", 64'(wbs_adr_o), 64'h24);
        idle_inputs();
        wbs_ack_i = 1'b1; wbs_err_i = 1'b1; wbs_dat_i = 32'h0BADF00D;
        step("ack+err prio", 0, 1, 0, 0, 0, 32'h0BADF00D);
        idle_inputs();
        wbm_cyc_i = 1'b0;
        step("b2b idle", 0, 0, 0, 0, 0, 32'h0BADF00D);

        // Timeout with a silent slave; the disabled-timeout instance keeps waiting
        request(32'h30, 32'h0, 1'b0, 4'hF);
        step("tmo c1", 1, 0, 0, 0, 0, 32'h0BADF00D);
        idle_inputs();
        step("tmo c2", 1, 0, 0, 0, 0, 32'h0BADF00D);
        step("tmo c3", 1, 0, 0, 0, 0, 32'h0BADF00D);
        step("tmo c4", 1, 0, 0, 0, 0, 32'h0BADF00D);
        wbs_dat_i = 32'h77777777;
        step("tmo c5 err", 0, 0, 1, 0, 1, 32'h0BADF00D);
        step("tmo c6 idle", 0, 0, 0, 0, 0, 32'h0BADF00D);
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        chk("no-timeout stb/cyc held", 64'({z_stb_o, z_cyc_o, z_err_o, z_tmo_o}), 64'b1100);
        wbm_cyc_i = 1'b0;
        @(posedge clk); #1;
        chk("no-timeout abort", 64'({z_stb_o, z_cyc_o, z_ack_o, z_err_o}), 64'b0000);

        // Response arriving in the cycle the timeout would fire
        request(32'h40, 32'h0, 1'b0, 4'hF);
        step("race c1", 1, 0, 0, 0, 0, 32'h0BADF00D);
        idle_inputs();
        step("race c2", 1, 0, 0, 0, 0, 32'h0BADF00D);
        step("race c3", 1, 0, 0, 0, 0, 32'h0BADF00D);
        step("race c4", 1, 0, 0, 0, 0, 32'h0BADF00D);
        wbs_rty_i = 1'b1; wbs_dat_i = 32'h13579BDF;
        step("race c5 rty", 0, 0, 0, 1, 0, 32'h13579BDF);
        wbs_rty_i = 1'b0; wbs_ack_i = 1'b1; wbs_dat_i = 32'h2;
        step("ack in RESP ignored", 0, 0, 0, 0, 0, 32'h13579BDF);
        step("ack in IDLE ignored", 0, 0, 0, 0, 0, 32'h13579BDF);
        idle_inputs();

        // Abort: cyc drops in cycle 2 while a response arrives
        request(32'h50, 32'h0, 1'b0, 4'hF);
        step("abort c1", 1, 0, 0, 0, 0, 32'h13579BDF);
        idle_inputs();
        step("abort c2", 1, 0, 0, 0, 0, 32'h13579BDF);
        wbm_cyc_i = 1'b0; wbs_ack_i = 1'b1; wbs_dat_i = 32'h3;
        step("abort c3", 0, 0, 0, 0, 0, 32'h13579BDF);
        idle_inputs();
        step("abort c4", 0, 0, 0, 0, 0, 32'h13579BDF);

        // Reset during ACTIVE, request held through reset
        request(32'h60, 32'h99, 1'b1, 4'hF);
        step("rstact c1", 1, 0, 0, 0, 0, 32'h13579BDF);
        step("rstact c2", 1, 0, 0, 0, 0, 32'h13579BDF);
        rst = 1'b1;
        step("rstact c3", 0, 0, 0, 0, 0, 32'h0);
        chk("rstact wbs_adr/dat/sel/we", {wbs_adr_o, wbs_dat_o[30:0], wbs_sel_o, wbs_we_o}, 64'h0);
        rst = 1'b0;
        step("post-rst capture", 1, 0, 0, 0, 0, 32'h0);
        idle_inputs();
        wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFEF00D;
        step("post-rst ack", 0, 1, 0, 0, 0, 32'hCAFEF00D);
        idle_inputs();
        wbm_cyc_i = 1'b0;
        step("final idle", 0, 0, 0, 0, 0, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
